if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined MIPS core: owns the program counter, issues word fetches to instruction memory over a request/response handshake, and feeds the IF/ID pipeline register consumed by the decode stage. It absorbs decode stalls with a one-entry hold buffer. It accepts control-flow redirects resolved in the memory stage, killing any in-flight fetch.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- imem_req  out  1  fetch request this cycle
- imem_addr  out  32  fetch byte address; bits [1:0] always 0
- imem_rvalid  in  1  response valid; at least 1 cycle after its request; never more than one outstanding
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- stall_DE  in  1  decode cannot accept; IF/ID register must hold
- redirect_ME  in  1  taken branch/jump resolved; flush and refetch
- redirect_pc_ME  in  32  new PC; bits [1:0] ignored and forced to 0
- instr_DE  out  32  IF/ID instruction
- pc_DE  out  32  IF/ID instruction address
- pcplus4_DE  out  32  pc_DE + 4
- valid_DE  out  1  IF/ID holds a live instruction

## Operation
- Registers: pc_q (next fetch address), state {FETCH, WAIT, DROP}, req_pc (address of outstanding fetch), hold buffer (buf_valid, buf_instr, buf_pc), IF/ID outputs.
- Response destination: IF/ID register if free (!valid_DE || !stall_DE) and buf_valid=0, else the hold buffer.
- Issue condition, without redirect_ME: (state=FETCH && !buf_valid) or (state=WAIT && imem_rvalid && response goes to IF/ID). imem_req is combinational on imem_rvalid. On issue: imem_addr=pc_q, req_pc<=pc_q, pc_q<=pc_q+4 (mod 2^32), state->WAIT.
- WAIT, response without reissue: state->FETCH.
- IF/ID update when !stall_DE:
  - load from buffer if buf_valid; buffer clears.
  - else load the arriving response.
  - else valid_DE<=0.
- IF/ID update when stall_DE: hold all outputs. pcplus4_DE is registered alongside pc_DE.
- Redirect (highest priority, overrides stall_DE):
  - valid_DE<=0, buf_valid<=0, pc_q<=redirect_pc_ME&~3; no request that cycle.
  - WAIT with imem_rvalid=0 -> DROP.
  - WAIT with imem_rvalid=1 -> response discarded, FETCH.
  - FETCH stays FETCH.
  - DROP stays DROP with new pc_q.
- DROP: no requests. On imem_rvalid, discard the response and go to FETCH.
- Reset (asynchronous, any state):
  - pc_q=RESET_PC, state=FETCH, buf_valid=0.
  - valid_DE=0, instr_DE=0, pc_DE=0, pcplus4_DE=0.
  - imem_req=0 and imem_addr=0 while reset is high.
  - Instruction memory shares reset and drops its outstanding response.

## Timing
- First request in the first cycle after reset deasserts, addr=RESET_PC.
- With 1-cycle memory: request at cycle n, rvalid at n+1, valid_DE visible at n+2. Sustained throughput 1 instruction/cycle.
- Redirect at cycle n: first new request at n+1 from FETCH. From DROP, the first new request comes in the cycle after the discarded response.
- Stall with a full buffer: no issue; at most one instruction is buffered, so nothing is lost.
- Buffered instruction reaches IF/ID in the first cycle stall_DE is low.
- No combinational path from stall_DE or redirect_ME to instr_DE.

## Structure
- Shared package mips_pkg: RESET_PC default, fetch state enum (FETCH/WAIT/DROP), word width 32, PC increment constant 4.
- One sub-module, if_hold_buf: one-entry buffer with load/drain/clear and valid flag. The FSM, PC and IF/ID register stay in if_stage.

## Test plan
- Reset, 1-cycle memory returning addr-tagged words, no stalls:
  - fetches issue at 0x0, 0x4, 0x8 on consecutive cycles.
  - valid_DE high from cycle 2; pc_DE 0x0, 0x4, 0x8 consecutively; pcplus4_DE = pc_DE+4.
- stall_DE held 3 cycles while 0x8's response arrives:
  - IF/ID holds 0x4; 0x8 is buffered; no request issues.
  - After stall release, pc_DE=0x8, then fetch of 0xC resumes.
- redirect_ME with redirect_pc_ME=0x43 while a 3-cycle-latency fetch of 0x10 is outstanding:
  - valid_DE=0 next cycle; state DROP; the 0x10 response is discarded.
  - Next request has imem_addr=0x40.
- redirect_ME asserted in the same cycle as stall_DE and a buffered instruction: buffer and IF/ID flushed; next instruction delivered is from the redirect target.
- pc_q=0xFFFF_FFFC: fetch issues at 0xFFFF_FFFC, next at 0x0; pcplus4_DE=0x0 for that instruction.
- Reset asserted mid-WAIT with stall active: all outputs return to reset values immediately; first post-reset request goes to RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core: word width, PC constants
// and the instruction-fetch state encoding.
package mips_pkg;

    localparam int          WORD_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid buffer that catches a fetch response arriving while decode is
// stalled with a live instruction.
module if_hold_buf
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              drain,
    input  logic              clear,
    input  logic [WORD_W-1:0] load_instr,
    input  logic [WORD_W-1:0] load_pc,
    output logic              buf_valid,
    output logic [WORD_W-1:0] buf_instr,
    output logic [WORD_W-1:0] buf_pc
);

    // Clear (flush) beats load so a redirect never leaves a stale entry behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_instr <= '0;
            buf_pc    <= '0;
        end else if (clear) begin
            buf_valid <= 1'b0;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_instr <= load_instr;
            buf_pc    <= load_pc;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, hold buffer
// and IF/ID pipeline register, with memory-stage redirects killing fetches.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              stall_DE,
    input  logic              redirect_ME,
    input  logic [WORD_W-1:0] redirect_pc_ME,
    output logic [WORD_W-1:0] instr_DE,
    output logic [WORD_W-1:0] pc_DE,
    output logic [WORD_W-1:0] pcplus4_DE,
    output logic              valid_DE
);

    fetch_state_t      state, state_next;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] req_pc;
    logic              buf_valid;
    logic [WORD_W-1:0] buf_instr;
    logic [WORD_W-1:0] buf_pc;
    logic              resp;
    logic              ifid_free;
    logic              resp_to_ifid;
    logic              resp_to_buf;
    logic              issue;

    // A new fetch may follow a response in the same cycle only if that
    // response lands in IF/ID; otherwise the buffer would be oversubscribed.
    always_comb begin
        resp         = (state == WAIT) && imem_rvalid;
        ifid_free    = (!valid_DE || !stall_DE) && !buf_valid;
        resp_to_ifid = resp && ifid_free && !redirect_ME;
        resp_to_buf  = resp && !ifid_free && !redirect_ME;
        issue        = !redirect_ME &&
                       (((state == FETCH) && !buf_valid) || (resp && ifid_free));
    end

    assign imem_req  = issue && !reset;
    assign imem_addr = imem_req ? pc_q : '0;

    always_comb begin
        state_next = state;
        if (redirect_ME) begin
            case (state)
                WAIT:    state_next = imem_rvalid ? FETCH : DROP;
                DROP:    state_next = imem_rvalid ? FETCH : DROP;
                default: state_next = FETCH;
            endcase
        end else if (issue) begin
            state_next = WAIT;
        end else if ((state == WAIT || state == DROP) && imem_rvalid) begin
            state_next = FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= FETCH;
            pc_q   <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            state <= state_next;
            if (redirect_ME) begin
                pc_q <= word_align(redirect_pc_ME);
            end else if (issue) begin
                pc_q   <= pc_q + PC_INC;
                req_pc <= pc_q;
            end
        end
    end

    if_hold_buf u_hold_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (resp_to_buf),
        .drain      (!stall_DE && !redirect_ME),
        .clear      (redirect_ME),
        .load_instr (imem_rdata),
        .load_pc    (req_pc),
        .buf_valid  (buf_valid),
        .buf_instr  (buf_instr),
        .buf_pc     (buf_pc)
    );

    // An empty IF/ID accepts a response even while decode is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_DE   <= 1'b0;
            instr_DE   <= '0;
            pc_DE      <= '0;
            pcplus4_DE <= '0;
        end else if (redirect_ME) begin
            valid_DE <= 1'b0;
        end else if (buf_valid && !stall_DE) begin
            valid_DE   <= 1'b1;
            instr_DE   <= buf_instr;
            pc_DE      <= buf_pc;
            pcplus4_DE <= buf_pc + PC_INC;
        end else if (resp_to_ifid) begin
            valid_DE   <= 1'b1;
            instr_DE   <= imem_rdata;
            pc_DE      <= req_pc;
            pcplus4_DE <= req_pc + PC_INC;
        end else if (!stall_DE) begin
            valid_DE <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed timing scenarios, then random
// stalls/redirects/latencies scored against the expected program-order stream.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_DE;
    logic        redirect_ME;
    logic [31:0] redirect_pc_ME;
    logic [31:0] instr_DE;
    logic [31:0] pc_DE;
    logic [31:0] pcplus4_DE;
    logic        valid_DE;

    int errors = 0;
    int checks = 0;

    logic        mem_pending;
    logic [31:0] mem_addr;
    int          mem_left;
    int          lat;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc, s_pc4;

    logic [31:0] exp_fetch;
    logic [31:0] exp_cons;
    int          consumed;

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stall_DE       (stall_DE),
        .redirect_ME    (redirect_ME),
        .redirect_pc_ME (redirect_pc_ME),
        .instr_DE       (instr_DE),
        .pc_DE          (pc_DE),
        .pcplus4_DE     (pcplus4_DE),
        .valid_DE       (valid_DE)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ a ^ 32'hC0DE_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Instruction memory: one outstanding request, response after lat cycles.
    task automatic memStep();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_pending) begin
            mem_left--;
            if (mem_left <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = tag(mem_addr);
                mem_pending = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive inputs, sample at negedge, score the stream.
    task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] rpc);
        stall_DE       = stall;
        redirect_ME    = redir;
        redirect_pc_ME = rpc;
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = valid_DE;
        s_instr = instr_DE;
        s_pc    = pc_DE;
        s_pc4   = pcplus4_DE;
        if (redir) checkOutput("no_req_on_redirect", {31'd0, s_req}, 32'd0);
        if (s_req) begin
            checkOutput("one_outstanding", {31'd0, mem_pending}, 32'd0);
            checkOutput("fetch_addr", s_addr, exp_fetch);
            mem_pending = 1'b1;
            mem_addr    = s_addr;
            mem_left    = lat;
        end
        if (redir) begin
            exp_fetch = rpc & ~32'd3;
            exp_cons  = rpc & ~32'd3;
        end else begin
            if (s_req) exp_fetch = exp_fetch + 32'd4;
            if (s_valid && !stall) begin
                checkOutput("cons_pc", s_pc, exp_cons);
                checkOutput("cons_instr", s_instr, tag(exp_cons));
                checkOutput("cons_pcplus4", s_pc4, exp_cons + 32'd4);
                exp_cons = exp_cons + 32'd4;
                consumed++;
            end
        end
        @(posedge clk);
        #1;
        memStep();
    endtask

    task automatic expectFetch(input logic req, input logic [31:0] addr);
        checkOutput("imem_req", {31'd0, s_req}, {31'd0, req});
        if (req) checkOutput("imem_addr", s_addr, addr);
    endtask

    task automatic expectIfid(input logic valid, input logic [31:0] pc);
        checkOutput("valid_DE", {31'd0, s_valid}, {31'd0, valid});
        if (valid) begin
            checkOutput("pc_DE", s_pc, pc);
            checkOutput("pcplus4_DE", s_pc4, pc + 32'd4);
            checkOutput("instr_DE", s_instr, tag(pc));
        end
    endtask

    // Asserts reset, checks outputs asynchronously, releases mid-cycle.
    task automatic doReset();
        reset = 1'b1;
        #1;
        checkOutput("rst_imem_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_imem_addr", imem_addr, 32'd0);
        checkOutput("rst_valid_DE", {31'd0, valid_DE}, 32'd0);
        checkOutput("rst_instr_DE", instr_DE, 32'd0);
        checkOutput("rst_pc_DE", pc_DE, 32'd0);
        checkOutput("rst_pcplus4_DE", pcplus4_DE, 32'd0);
        mem_pending = 1'b0;
        imem_rvalid = 1'b0;
        stall_DE    = 1'b0;
        redirect_ME = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        exp_fetch = 32'h0;
        exp_cons  = 32'h0;
    endtask

    initial begin
        logic        r_stall;
        logic        r_redir;
        logic [31:0] r_tgt;

        reset          = 1'b0;
        stall_DE       = 1'b0;
        redirect_ME    = 1'b0;
        redirect_pc_ME = 32'h0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        mem_pending    = 1'b0;
        mem_addr       = 32'h0;
        mem_left       = 0;
        lat            = 1;
        consumed       = 0;
        exp_fetch      = 32'h0;
        exp_cons       = 32'h0;
        $display("[TB] if_stage bench starting");
        #2;
        doReset();

        // Streaming with 1-cycle memory
        applyStimulus(1'b0, 1'b0, 32'h0); expectFetch(1'b1, 32'h0); expectIfid(1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0); expectFetch(1'b1, 32'h4); expectIfid(1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0); expectFetch(1'b1, 32'h8); expectIfid(1'b1, 32'h0);

        // Stall for 3 cycles while 0x8 arrives and is buffered
        applyStimulus(1'b1, 1'b0, 32'h0); expectFetch(1'b0, 32'h0); expectIfid(1'b1, 32'h4);
        applyStimulus(1'b1, 1'b0, 32'h0); expectFetch(1'b0, 32'h0); expectIfid(1'b1, 32'h4);
        applyStimulus(1'b1, 1'b0, 32'h0); expectFetch(1'b0, 32'h0); expectIfid(1'b1, 32'h4);
        applyStimulus(1'b0, 1'b0, 32'h0); expectFetch(1'b0, 32'h0); expectIfid(1'b1, 32'h4);
        applyStimulus(1'b0, 1'b0, 32'h0); expectFetch(1'b1, 32'hC); expectIfid(1'b1, 32'h8);

        // Redirect to 0x43 while a 3-cycle fetch of 0x10 is outstanding
        lat = 3;
        applyStimulus(1'b0, 1'b0, 32'h0);  expectFetch(1'b1, 32'h10); expectIfid(1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h43); expectFetch(1'b0, 32'h0);  expectIfid(1'b1, 32'hC);
        applyStimulus(1'b0, 1'b0, 32'h0);  expectFetch(1'b0, 32'h0);  expectIfid(1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);  expectFetch(1'b0, 32'h0);  expectIfid(1'b0, 32'h0);
        lat = 1;
        applyStimulus(1'b0, 1'b0, 32'h0);  expectFetch(1'b1, 32'h40); expectIfid(1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);  expectFetch(1'b1, 32'h44); expectIfid(1'b0, 32'h0);

        // Redirect together with stall and a buffered instruction
        applyStimulus(1'b1, 1'b0, 32'h0);   expectFetch(1'b0, 32'h0);   expectIfid(1'b1, 32'h40);
        applyStimulus(1'b1, 1'b1, 32'h100); expectFetch(1'b0, 32'h0);   expectIfid(1'b1, 32'h40);
        applyStimulus(1'b0, 1'b0, 32'h0);   expectFetch(1'b1, 32'h100); expectIfid(1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);   expectFetch(1'b1, 32'h104); expectIfid(1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);   expectFetch(1'b1, 32'h108); expectIfid(1'b1, 32'h100);

        // PC wrap at the top of the address space
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE); expectFetch(1'b0, 32'h0);         expectIfid(1'b1, 32'h104);
        applyStimulus(1'b0, 1'b0, 32'h0);         expectFetch(1'b1, 32'hFFFF_FFFC); expectIfid(1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);         expectFetch(1'b1, 32'h0);         expectIfid(1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);         expectFetch(1'b1, 32'h4);         expectIfid(1'b1, 32'hFFFF_FFFC);
        checkOutput("wrap_pcplus4", s_pc4, 32'h0);
        lat = 3;
        applyStimulus(1'b0, 1'b0, 32'h0);         expectFetch(1'b1, 32'h8);         expectIfid(1'b1, 32'h0);

        // Reset in WAIT with stall active
        applyStimulus(1'b1, 1'b0, 32'h0);         expectFetch(1'b0, 32'h0);         expectIfid(1'b1, 32'h4);
        stall_DE = 1'b1;
        doReset();
        lat = 1;
        applyStimulus(1'b0, 1'b0, 32'h0);         expectFetch(1'b1, 32'h0);         expectIfid(1'b0, 32'h0);

        // Random stalls, redirects and memory latency
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            lat     = $urandom_range(1, 4);
            r_stall = ($urandom_range(0, 9) < 3);
            r_redir = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0)
                r_tgt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            else
                r_tgt = $urandom;
            applyStimulus(r_stall, r_redir, r_tgt);
        end
        checkOutput("random_progress", {31'd0, (consumed > 300)}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
